fmap_stream_tx: RTL and testbench
=================================

// Module: fmap_stream_tx
// PURPOSE
//  Transmit end of the row-stream protocol consumed by the row-buffer/sign groups: converts a
//  valid/ready feature-map word source into the vsync/hsync/reuse/valid/tdata frame stream.
//  Buffers one row, then emits it REPEAT times (pass 0 reuse=0, later passes reuse=1) with HGAP idle gaps.
//  Sits between a layer's result buffer and the next group's input.
// PARAMETERS
//  WIDTH_D  27  data word width
//  SIZE     56  words per row (row length)
//  ROWS     56  rows per frame
//  REPEAT   1   transmissions of each row; must be >=1
//  HGAP     21  idle cycles after a row pass before the next hsync; must be >=1
//  VS_LEN   4   cycles o_vsync is held high at frame start; must be >=1
// PORTS
//  i_sclk   in   1        clock
//  i_rst_n  in   1        asynchronous active-low reset
//  i_start  in   1        start one frame (sampled in IDLE only)
//  i_valid  in   1        upstream word valid
//  i_tdata  in   WIDTH_D  upstream word
//  o_ready  out  1        word accepted when i_valid & o_ready
//  o_vsync  out  1        frame-start / downstream FIFO reset
//  o_hsync  out  1        1-cycle pulse preceding each row pass
//  o_reuse  out  1        high on every beat of passes 1..REPEAT-1
//  o_valid  out  1        data beat valid
//  o_tdata  out  WIDTH_D  row word; forced 0 when o_valid=0
//  o_busy   out  1        high from accepted i_start until o_done
//  o_done   out  1        1-cycle pulse after last beat of last pass of last row
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0; buffer contents don't-care.
//  - All outputs registered. FSM: IDLE -> VSYNC -> FILL -> HSYNC -> SEND -> GAP -> (HSYNC|FILL|DONE) -> IDLE.
//  - IDLE: i_start=1 -> VSYNC next cycle, o_busy=1. i_start ignored in any other state.
//  - VSYNC: o_vsync=1 for exactly VS_LEN cycles, then FILL.
//  - FILL: o_ready=1; each handshake writes word to buffer addr col, col++. Stalls (i_valid=0) just wait.
//    After SIZE-th accepted word, o_ready drops next cycle -> HSYNC. i_valid while o_ready=0 is not accepted.
//  - HSYNC: o_hsync=1 one cycle; o_reuse for the following pass = (pass!=0).
//  - SEND: SIZE consecutive beats, o_valid=1 every cycle, word k on beat k (k=0..SIZE-1), no bubbles.
//    Buffer read latency 1 -> issue read address 0 during HSYNC.
//    First beat exactly 1 cycle after hsync cycle.
//  - GAP: HGAP cycles, all stream outputs 0. Then: pass<REPEAT-1 -> pass++, HSYNC;
//    else row<ROWS-1 -> row++, pass=0, FILL; else DONE.
//  - DONE: o_done=1 one cycle, o_busy=0 same edge, -> IDLE. Back-to-back i_start in that cycle ignored.
//  - Counters: col ceil(log2(SIZE+1)), pass ceil(log2(REPEAT+1)), row ceil(log2(ROWS+1)) bits; no wrap beyond terminal.
//  - Reset mid-frame: immediate return to IDLE outputs; next frame restarts at row 0 with VSYNC.
//  - Per-frame cycle count (no upstream stalls): VS_LEN + ROWS*(SIZE + REPEAT*(1+SIZE+HGAP)) + 1.
// STRUCTURE
//  - fmap_stream_pkg: state enum (IDLE,VSYNC,FILL,HSYNC,SEND,GAP,DONE), clog2-based width functions.
//  - Sub-module fmap_row_buf: SIZE x WIDTH_D simple dual-port RAM, 1 write port, 1 registered read port.
//    Infers block/distributed RAM.
//  - Top: FSM, counters, output registers, zero-masking of o_tdata.
// TESTING  (bench params SIZE=4, ROWS=2, REPEAT=2, HGAP=3, VS_LEN=2)
//  1. i_start pulse, upstream always valid with words 1..8:
//     -> vsync 2 cycles; row0 words 1,2,3,4 sent twice (reuse 0 then 1); row1 words 5..8 twice.
//     -> o_done after 2+2*(4+2*8)+1=43 cycles.
//  2. Upstream drops i_valid for 5 cycles mid-FILL of row1:
//     -> only 4 words accepted; o_ready holds; SEND beats contiguous, identical data to test 1.
//  3. Check o_tdata==0 and o_reuse==0 on every o_valid=0 cycle; hsync exactly 4 pulses/frame, each 1 cycle before a 4-beat burst.
//  4. i_start asserted during SEND and on the o_done cycle -> ignored; second frame only on later IDLE start.
//  5. Deassert i_rst_n during row0 pass1 -> all outputs 0 asynchronously.
//     Release + i_start -> clean frame from vsync, row0 data again.
//  6. REPEAT=1, HGAP=1: -> o_reuse never asserted; gap between bursts exactly 1 idle cycle + hsync.

Source files
------------

// File: rtl/fmap_stream_pkg.sv
// Shared types and width helpers for the feature-map row-stream transmitter.
//   state_t   : frame FSM states
//   f_cnt_w   : bits needed to hold 0..n
//   f_addr_w  : bits needed to address n entries (never below 1)
//   f_max     : larger of two integers
package fmap_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_FILL,
    ST_HSYNC,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic int f_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int f_addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fmap_stream_tx_if.sv
// Bundle of the upstream word handshake and the downstream frame stream.
//   master : environment side (drives start/valid/tdata, observes stream)
//   slave  : transmitter side (fmap_stream_tx)
interface fmap_stream_tx_if #(
  parameter int WIDTH_D = 27
);
  logic               i_start;
  logic               i_valid;
  logic [WIDTH_D-1:0] i_tdata;
  logic               o_ready;
  logic               o_vsync;
  logic               o_hsync;
  logic               o_reuse;
  logic               o_valid;
  logic [WIDTH_D-1:0] o_tdata;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_valid, i_tdata,
    input  o_ready, o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_busy, o_done
  );

  modport slave (
    input  i_start, i_valid, i_tdata,
    output o_ready, o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_busy, o_done
  );
endinterface

// File: rtl/fmap_row_buf.sv
// One-row buffer: SIZE x WIDTH_D simple dual-port RAM, one write port and one
// read port with a registered output (read latency 1). No reset on the array or
// the read register so it maps onto block/distributed RAM.
//   i_sclk          clock
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr    read request; o_rdata valid the following cycle
module fmap_row_buf #(
  parameter int WIDTH_D = 27,
  parameter int SIZE    = 56,
  parameter int AW      = 6
) (
  input  logic               i_sclk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [WIDTH_D-1:0] i_wdata,
  input  logic               i_re,
  input  logic [AW-1:0]      i_raddr,
  output logic [WIDTH_D-1:0] o_rdata
);
  logic [WIDTH_D-1:0] r_mem [SIZE];
  logic [WIDTH_D-1:0] r_rdata;

  always_ff @(posedge i_sclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fmap_stream_tx.sv
// Row-stream transmitter: buffers one row from a valid/ready word source, then
// replays it REPEAT times as hsync + SIZE contiguous beats + HGAP idle cycles.
// A frame starts with VS_LEN cycles of vsync and ends with a one-cycle done.
//   i_sclk   clock
//   i_rst_n  asynchronous active-low reset
//   bus      fmap_stream_tx_if.slave: i_start, i_valid, i_tdata in;
//            o_ready, o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_busy, o_done out
module fmap_stream_tx
  import fmap_stream_pkg::*;
#(
  parameter int WIDTH_D = 27,
  parameter int SIZE    = 56,
  parameter int ROWS    = 56,
  parameter int REPEAT  = 1,
  parameter int HGAP    = 21,
  parameter int VS_LEN  = 4
) (
  input  logic           i_sclk,
  input  logic           i_rst_n,
  fmap_stream_tx_if.slave bus
);
  localparam int CW = f_cnt_w(SIZE);
  localparam int PW = f_cnt_w(REPEAT);
  localparam int RW = f_cnt_w(ROWS);
  localparam int GW = f_cnt_w(f_max(VS_LEN, HGAP));
  localparam int AW = f_addr_w(SIZE);

  localparam logic [CW-1:0] C_LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] C_SIZE = CW'(SIZE);
  localparam logic [PW-1:0] P_LAST = PW'(REPEAT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [GW-1:0] V_LAST = GW'(VS_LEN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(HGAP - 1);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_col,   w_col_next;
  logic [PW-1:0] r_pass,  w_pass_next;
  logic [RW-1:0] r_row,   w_row_next;
  logic [GW-1:0] r_cnt,   w_cnt_next;

  logic r_ready, r_vsync, r_hsync, r_reuse, r_valid, r_busy, r_done;
  logic w_ready_next, w_vsync_next, w_hsync_next, w_reuse_next;
  logic w_valid_next, w_busy_next, w_done_next;

  logic               w_acc;
  logic               w_re;
  logic [AW-1:0]      w_raddr;
  logic [WIDTH_D-1:0] w_rd_data;

  // r_ready is high exactly while in FILL, so it doubles as the state qualifier.
  assign w_acc = bus.i_valid & r_ready;

  // In SEND r_col is the address of the word for the next beat; address 0 is
  // fetched during HSYNC so the first beat lands the cycle after hsync.
  assign w_re    = (r_state == ST_HSYNC) || ((r_state == ST_SEND) && (r_col != C_SIZE));
  assign w_raddr = (r_state == ST_HSYNC) ? '0 : r_col[AW-1:0];

  fmap_row_buf #(
    .WIDTH_D(WIDTH_D),
    .SIZE   (SIZE),
    .AW     (AW)
  ) u_row_buf (
    .i_sclk (i_sclk),
    .i_we   (w_acc),
    .i_waddr(r_col[AW-1:0]),
    .i_wdata(bus.i_tdata),
    .i_re   (w_re),
    .i_raddr(w_raddr),
    .o_rdata(w_rd_data)
  );

  // State, counters and output registers.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_pass  <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_reuse <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_pass  <= w_pass_next;
      r_row   <= w_row_next;
      r_cnt   <= w_cnt_next;
      r_ready <= w_ready_next;
      r_vsync <= w_vsync_next;
      r_hsync <= w_hsync_next;
      r_reuse <= w_reuse_next;
      r_valid <= w_valid_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next state and counters.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_pass_next  = r_pass;
    w_row_next   = r_row;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_state_next = ST_VSYNC;
          w_col_next   = '0;
          w_pass_next  = '0;
          w_row_next   = '0;
          w_cnt_next   = '0;
        end
      end
      ST_VSYNC: begin
        if (r_cnt == V_LAST) begin
          w_state_next = ST_FILL;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_FILL: begin
        if (w_acc) begin
          if (r_col == C_LAST) begin
            w_state_next = ST_HSYNC;
            w_col_next   = '0;
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      ST_HSYNC: begin
        w_state_next = ST_SEND;
        w_col_next   = CW'(1);
      end
      ST_SEND: begin
        if (r_col == C_SIZE) begin
          w_state_next = ST_GAP;
          w_col_next   = '0;
          w_cnt_next   = '0;
        end else begin
          w_col_next = r_col + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == G_LAST) begin
          w_cnt_next = '0;
          if (r_pass != P_LAST) begin
            w_pass_next  = r_pass + 1'b1;
            w_state_next = ST_HSYNC;
          end else if (r_row != R_LAST) begin
            w_row_next   = r_row + 1'b1;
            w_pass_next  = '0;
            w_state_next = ST_FILL;
          end else begin
            w_state_next = ST_DONE;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    w_ready_next = (w_state_next == ST_FILL);
    w_vsync_next = (w_state_next == ST_VSYNC);
    w_hsync_next = (w_state_next == ST_HSYNC);
    w_valid_next = (w_state_next == ST_SEND);
    w_reuse_next = (w_state_next == ST_SEND) && (w_pass_next != '0);
    w_busy_next  = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
    w_done_next  = (w_state_next == ST_DONE);
  end

  assign bus.o_ready = r_ready;
  assign bus.o_vsync = r_vsync;
  assign bus.o_hsync = r_hsync;
  assign bus.o_reuse = r_reuse;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  // The RAM read register holds stale words between bursts; mask them off.
  assign bus.o_tdata = r_valid ? w_rd_data : '0;
endmodule

// File: tb/tb_fmap_stream_tx.sv
`timescale 1ns/1ps
module tb_fmap_stream_tx;
  localparam int W  = 8;
  localparam int SZ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmap_stream_tx_if #(.WIDTH_D(W)) b1 ();
  fmap_stream_tx_if #(.WIDTH_D(W)) b2 ();

  fmap_stream_tx #(.WIDTH_D(W), .SIZE(SZ), .ROWS(2), .REPEAT(2), .HGAP(3), .VS_LEN(2)) dut1 (
    .i_sclk(clk), .i_rst_n(rst_n), .bus(b1));
  fmap_stream_tx #(.WIDTH_D(W), .SIZE(SZ), .ROWS(2), .REPEAT(1), .HGAP(1), .VS_LEN(2)) dut2 (
    .i_sclk(clk), .i_rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;

  logic         sel = 1'b0;   // 0: observe dut1, 1: observe dut2
  logic         start = 1'b0;
  logic         v = 1'b0;
  logic [W-1:0] d = '0;
  logic         feed_en = 1'b0;
  logic         feed_clr = 1'b0;
  int           word_idx = 0;
  int           stall_at = -1;
  int           stall_rem = 0;
  int           hs_cnt = 0;
  logic [W:0]   exp_q[$];     // {reuse, data}

  assign b1.i_start = start & ~sel;
  assign b2.i_start = start & sel;
  assign b1.i_valid = v;
  assign b2.i_valid = v;
  assign b1.i_tdata = d;
  assign b2.i_tdata = d;

  wire         m_ready = sel ? b2.o_ready : b1.o_ready;
  wire         m_vsync = sel ? b2.o_vsync : b1.o_vsync;
  wire         m_hsync = sel ? b2.o_hsync : b1.o_hsync;
  wire         m_reuse = sel ? b2.o_reuse : b1.o_reuse;
  wire         m_valid = sel ? b2.o_valid : b1.o_valid;
  wire [W-1:0] m_tdata = sel ? b2.o_tdata : b1.o_tdata;
  wire         m_busy  = sel ? b2.o_busy  : b1.o_busy;
  wire         m_done  = sel ? b2.o_done  : b1.o_done;
  wire [14:0]  m_all   = {m_ready, m_vsync, m_hsync, m_reuse, m_valid, m_busy, m_done, m_tdata};

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Upstream source: word k carries value k+1; optional 5-cycle stall once
  // word_idx words have been accepted.
  logic f_acc;
  initial forever begin
    @(negedge clk);
    f_acc = v && m_ready;
    if (feed_en && !v && word_idx == stall_at)
      chk(m_ready, "ready_hold", m_ready, 1);
    @(posedge clk);
    #1;
    if (f_acc) word_idx++;
    if (feed_clr) begin
      word_idx = 0;
      feed_clr = 1'b0;
    end
    if (feed_en && word_idx == stall_at && stall_rem > 0) begin
      v = 1'b0;
      stall_rem--;
    end else begin
      v = feed_en;
    end
    d = W'(word_idx + 1);
  end

  // Monitor / scoreboard.
  logic prev_valid = 0, prev_hsync = 0, prev_ready = 0, had_beat = 0;
  int   burst_len = 0, since_beat = 0;
  logic [W:0] e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 0; prev_hsync = 0; prev_ready = 0; had_beat = 0;
      burst_len = 0; since_beat = 0;
    end else begin
      if (m_vsync) had_beat = 0;
      if (m_hsync) begin
        hs_cnt++;
        chk(!prev_hsync, "hsync_width", 2, 1);
      end
      if (m_valid) begin
        if (!prev_valid) begin
          chk(prev_hsync, "hsync_lead", prev_hsync, 1);
          if (m_reuse && had_beat)
            chk(since_beat == (sel ? 2 : 4), "pass_gap", since_beat, sel ? 2 : 4);
        end
        if (exp_q.size() == 0) begin
          chk(1'b0, "beat_unexpected", m_tdata, 0);
        end else begin
          e = exp_q.pop_front();
          chk({m_reuse, m_tdata} == e, "beat", {m_reuse, m_tdata}, e);
        end
        burst_len++;
        since_beat = 0;
        had_beat = 1;
      end else begin
        chk(m_tdata == 0 && m_reuse == 0, "idle_zero", {m_reuse, m_tdata}, 0);
        if (prev_valid) chk(burst_len == SZ, "burst_len", burst_len, SZ);
        burst_len = 0;
        if (m_ready && !prev_ready && had_beat)
          chk(since_beat == (sel ? 1 : 3), "row_gap", since_beat, sel ? 1 : 3);
        since_beat++;
      end
      prev_valid = m_valid;
      prev_hsync = m_hsync;
      prev_ready = m_ready;
    end
  end

  task automatic push_frame(input int rep);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < rep; p++)
        for (int c = 0; c < SZ; c++)
          exp_q.push_back({(p != 0), W'(r * SZ + c + 1)});
  endtask

  task automatic run_frame(input int rep, input int exp_cycles, input bit mid_start,
                           input bit done_start, input int stall_i);
    int  n;
    bit  done;
    push_frame(rep);
    hs_cnt    = 0;
    stall_at  = stall_i;
    stall_rem = 5;
    feed_clr  = 1'b1;
    feed_en   = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start = 1'b0;
      if (mid_start && n == 10) start = 1'b1;
      if (mid_start && n == 11) start = 1'b0;
      if (m_done) done = 1;
    end
    chk(done, "done_timeout", n, exp_cycles);
    chk(n == exp_cycles, "done_latency", n, exp_cycles);
    chk(m_busy == 0, "busy_at_done", m_busy, 0);
    if (done_start) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    feed_en = 1'b0;
    chk(m_done == 0, "done_pulse", m_done, 0);
    chk(hs_cnt == 2 * rep, "hsync_count", hs_cnt, 2 * rep);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk(m_busy == 0 && m_vsync == 0, "idle_after", {m_busy, m_vsync}, 0);
    end
    chk(word_idx == 2 * SZ, "words_accepted", word_idx, 2 * SZ);
    chk(exp_q.size() == 0, "queue_drain", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk(m_all == 0, "reset_state", m_all, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk(m_all == 0, "post_reset_idle", m_all, 0);

    run_frame(2, 43, 0, 0, -1);   // plain frame
    run_frame(2, 48, 0, 0, 6);    // 5-cycle stall in row1 fill
    run_frame(2, 43, 1, 1, -1);   // start during SEND and on done ignored

    // Reset during row0 pass1.
    push_frame(2);
    hs_cnt = 0; stall_at = -1; feed_clr = 1'b1; feed_en = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (exp_q.size() > 11 && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    chk(k < 200, "reset_wait", k, 200);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk(m_all == 0, "async_reset", m_all, 0);
    feed_en = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_frame(2, 43, 0, 0, -1);   // clean frame after reset

    // REPEAT=1, HGAP=1 instance.
    sel = 1'b1;
    @(posedge clk);
    #1 run_frame(1, 23, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
